// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and parity helper.
// Used by uart_rx, uart_tx and the benches.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 87;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Even parity bit for up to 8 data bits (unused upper bits must be zero).
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter
// so an idle-high serial line does not look like a start edge coming out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and break detection.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_t            r_state,     w_state_nxt;
    logic [CW-1:0]        r_clk_cnt,   w_clk_cnt_nxt;
    logic [IW-1:0]        r_bit_idx,   w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,      w_data_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 w_rxs;
    logic                 w_cnt_last;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad,    w_par_bad_nxt;
    logic                 r_parity_err, w_parity_err_nxt;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     (rx_serial),
        .o_q     (w_rxs)
    );

    assign w_cnt_last = (r_clk_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_parity_err_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                if (!w_rxs) w_state_nxt = START;
            end
            START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = w_rxs ? IDLE : DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_cnt_last) begin
                    w_clk_cnt_nxt          = '0;
                    w_shift_nxt[r_bit_idx] = w_rxs;
                    if (r_bit_idx == IDX_LAST) begin
                        w_bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt   = PARITY;
`else
                        w_state_nxt   = STOP;
`endif
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_cnt_last) begin
                    w_clk_cnt_nxt = '0;
                    w_par_bad_nxt = (w_rxs != even_parity(8'(r_shift)));
                    w_state_nxt   = STOP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                // Sampling at mid-stop and leaving early lets a back-to-back start edge be caught.
                if (w_cnt_last) begin
                    w_clk_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                    w_parity_err_nxt = r_par_bad;
`endif
                    if (w_rxs) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            BREAK: begin
                w_clk_cnt_nxt = '0;
                if (w_rxs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Shift register contents only matter once a full frame has been sampled.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end
    assign rx_parity_err = r_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level event model.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DBITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DBITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ferr;
        bit         perr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        got_q[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         overlap_cnt = 0;
    int         wide_cnt    = 0;
    int         stray_perr  = 0;
    logic [7:0] model_data  = 8'h00;
    logic       prev_valid  = 1'b0;
    logic       prev_ferr   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every result pulse the receiver emits
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid && rx_frame_err) overlap_cnt++;
            if ((rx_valid && prev_valid) || (rx_frame_err && prev_ferr)) wide_cnt++;
            if (rx_parity_err && !rx_valid && !rx_frame_err) stray_perr++;
            if (rx_valid || rx_frame_err)
                got_q.push_back('{ferr: rx_frame_err, perr: rx_parity_err, data: rx_data});
        end
        prev_valid = rx_valid;
        prev_ferr  = rx_frame_err;
    end

    // All drive tasks start and end 1 time unit after a rising edge
    task automatic drive_bit(input logic b, input int cycles);
        rx_serial = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        drive_bit(1'b1, cycles);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok);
        ev_t e;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < DBITS; i++) drive_bit(data[i], CPB);
        if (PAR_ON) drive_bit((^data) ^ !par_ok, CPB);
        drive_bit(stop_ok, CPB);
        if (stop_ok) model_data = data;
        e.ferr = !stop_ok;
        e.perr = PAR_ON && !par_ok;
        e.data = model_data;
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        ev_t g;
        ev_t x;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            check({tag, "_ferr"}, g.ferr, x.ferr);
            check({tag, "_perr"}, g.perr, x.perr);
            check({tag, "_data"}, g.data, x.data);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_busy_after"}, rx_busy, 1'b0);
        check({tag, "_rx_data_held"}, rx_data, model_data);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         stop_ok;
        bit         par_ok;
        int         gap;

        rst       = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",   rx_data, 8'h00);
        check("reset_valid",  rx_valid, 1'b0);
        check("reset_ferr",   rx_frame_err, 1'b0);
        check("reset_perr",   rx_parity_err, 1'b0);
        check("reset_busy",   rx_busy, 1'b0);
        rst = 1'b1;
        idle(CPB);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(4);
        compare_events("loopback");

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(4);
        compare_events("back2back");

        drive_bit(1'b0, 4);
        drive_bit(1'b1, 10);
        check("glitch_busy_drop", rx_busy, 1'b0);
        idle(2 * CPB);
        compare_events("glitch");

        // Stop bit low, line kept low three bit times in total, then a frame's worth of idle
        send_frame(8'h55, 1'b0, 1'b1);
        drive_bit(1'b0, 2 * CPB);
        check("break_busy_held", rx_busy, 1'b1);
        idle(12 * CPB);
        compare_events("frame_err");

        // Reset asserted in the middle of bit 3 of 0x81
        d = 8'h81;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bit(d[i], CPB);
        drive_bit(d[3], CPB / 2);
        rst       = 1'b0;
        rx_serial = 1'b1;
        #2;
        check("midrst_data",  rx_data, 8'h00);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_ferr",  rx_frame_err, 1'b0);
        check("midrst_perr",  rx_parity_err, 1'b0);
        check("midrst_busy",  rx_busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b1;
        model_data = 8'h00;
        idle(CPB);
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(4);
        compare_events("after_reset");

        if (PAR_ON) begin
            send_frame(8'h07, 1'b1, 1'b0);
            idle(4);
            compare_events("parity_bad");
        end

        for (int k = 0; k < 24; k++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, par_ok);
            if (!stop_ok) idle(CPB);
            gap = $urandom_range(0, CPB);
            if (gap > 0) idle(gap);
        end
        idle(4);
        compare_events("random");

        check("valid_ferr_overlap", overlap_cnt, 0);
        check("pulse_width",        wide_cnt, 0);
        check("stray_parity_err",   stray_perr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
